// File: rtl/din_stream_gen.sv
// Burst stimulus source: emits bursts of arithmetic-sequence words separated by idle gaps.
// Optional macro DIN_GEN_SUM_TAIL_EN adds a per-burst checksum tail word.
module din_stream_gen #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [DWIDTH-1:0] cfg_base,
    input  logic [DWIDTH-1:0] cfg_step,
    input  logic [15:0]       cfg_len,
    input  logic [7:0]        cfg_bursts,
    input  logic [7:0]        cfg_gap,
    output logic              dout_valid,
    output logic [DWIDTH-1:0] dout_data,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

`ifdef DIN_GEN_SUM_TAIL_EN
    localparam bit HAS_TAIL = 1'b1;
    typedef enum logic [2:0] {IDLE, BURST, TAIL, GAP, DONE} state_t;
`else
    localparam bit HAS_TAIL = 1'b0;
    typedef enum logic [2:0] {IDLE, BURST, GAP, DONE} state_t;
`endif

    // The state names what is on the bus this cycle; counters describe that word.
    state_t            state, state_n;
    logic [15:0]       len_q, len_n;
    logic [7:0]        bursts_q, bursts_n;
    logic [7:0]        gap_q, gap_n;
    logic [DWIDTH-1:0] step_q, step_n;
    logic [15:0]       word_cnt, word_cnt_n;
    logic [7:0]        burst_cnt, burst_cnt_n;
    logic [7:0]        gap_cnt, gap_cnt_n;
    logic [DWIDTH-1:0] next_word, next_word_n;
`ifdef DIN_GEN_SUM_TAIL_EN
    logic [DWIDTH-1:0] acc, acc_n;
`endif
    logic              valid_n, last_n, busy_n, done_n;
    logic [DWIDTH-1:0] data_n;
    logic              end_burst, new_burst;

    // NOTE: every variable gets a default before the case so no path infers a latch;
    // blocking assignments here let later sections see earlier updates in the same cycle.
    always_comb begin
        state_n     = state;
        len_n       = len_q;
        bursts_n    = bursts_q;
        gap_n       = gap_q;
        step_n      = step_q;
        word_cnt_n  = word_cnt;
        burst_cnt_n = burst_cnt;
        gap_cnt_n   = gap_cnt;
        next_word_n = next_word;
`ifdef DIN_GEN_SUM_TAIL_EN
        acc_n       = acc;
`endif
        valid_n     = 1'b0;
        data_n      = dout_data;
        last_n      = 1'b0;
        busy_n      = busy;
        done_n      = 1'b0;
        end_burst   = 1'b0;
        new_burst   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    len_n       = cfg_len;
                    bursts_n    = cfg_bursts;
                    gap_n       = cfg_gap;
                    step_n      = cfg_step;
                    next_word_n = cfg_base;
                    burst_cnt_n = 8'd0;
                    if (cfg_len != 16'd0 && cfg_bursts != 8'd0) begin
                        new_burst = 1'b1;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b1;
                    end
                end
            end
            BURST: begin
                if (stop) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (word_cnt < len_q) begin
                    valid_n     = 1'b1;
                    data_n      = next_word;
                    last_n      = (word_cnt + 16'd1 == len_q) && !HAS_TAIL;
                    word_cnt_n  = word_cnt + 16'd1;
                    next_word_n = next_word + step_q;
`ifdef DIN_GEN_SUM_TAIL_EN
                    acc_n       = acc + next_word;
`endif
                end else begin
`ifdef DIN_GEN_SUM_TAIL_EN
                    state_n = TAIL;
                    valid_n = 1'b1;
                    data_n  = acc;
                    last_n  = 1'b1;
`else
                    end_burst = 1'b1;
`endif
                end
            end
`ifdef DIN_GEN_SUM_TAIL_EN
            TAIL: begin
                if (stop) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    end_burst = 1'b1;
                end
            end
`endif
            GAP: begin
                if (stop) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (gap_cnt < gap_q) begin
                    gap_cnt_n = gap_cnt + 8'd1;
                end else begin
                    new_burst = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase

        if (end_burst) begin
            if (burst_cnt < bursts_q) begin
                if (gap_q != 8'd0) begin
                    state_n   = GAP;
                    gap_cnt_n = 8'd1;
                end else begin
                    new_burst = 1'b1;
                end
            end else begin
                state_n = DONE;
                done_n  = 1'b1;
            end
        end

        // First word of a burst; next_word_n already holds the right value here.
        if (new_burst) begin
            state_n     = BURST;
            busy_n      = 1'b1;
            valid_n     = 1'b1;
            data_n      = next_word_n;
            last_n      = (len_n == 16'd1) && !HAS_TAIL;
            word_cnt_n  = 16'd1;
            burst_cnt_n = burst_cnt_n + 8'd1;
`ifdef DIN_GEN_SUM_TAIL_EN
            acc_n       = next_word_n;
`endif
            next_word_n = next_word_n + step_n;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; every register, including
    // the latched configuration, is reset so the block is fully defined after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            bursts_q   <= '0;
            gap_q      <= '0;
            step_q     <= '0;
            word_cnt   <= '0;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            next_word  <= '0;
`ifdef DIN_GEN_SUM_TAIL_EN
            acc        <= '0;
`endif
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            len_q      <= len_n;
            bursts_q   <= bursts_n;
            gap_q      <= gap_n;
            step_q     <= step_n;
            word_cnt   <= word_cnt_n;
            burst_cnt  <= burst_cnt_n;
            gap_cnt    <= gap_cnt_n;
            next_word  <= next_word_n;
`ifdef DIN_GEN_SUM_TAIL_EN
            acc        <= acc_n;
`endif
            dout_valid <= valid_n;
            dout_data  <= data_n;
            dout_last  <= last_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule
